// File: rtl/vsd_timer_irq_ctrl.sv
// vsd_timer_irq_ctrl: event capture and interrupt controller downstream of the
// VSD timer. Detects rising edges on NSRC event inputs, latches them in sticky
// PEND bits, flags overruns in OVR, counts events per source with saturation,
// and drives a maskable level irq. Register bus: sel/we/addr/wdata/rdata.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   sel, we, addr, wdata bus request (write on sel&we, read on sel&~we)
//   rdata                combinational read data (0 when not reading)
//   evt_in[NSRC-1:0]     synchronous event inputs (bit 0 = timer timeout)
//   irq                  gen & |(PEND & MASK)
//
// Map: 0x00 CTRL.gen, 0x04 MASK, 0x08 PEND (W1C), 0x0C OVR (W1C),
//      0x10+4*i COUNT_i (any write clears).

// Per-source lane: edge detect, sticky pending/overrun, saturating counter.
module vsd_timer_irq_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             gen_i,
  input  logic             evt_i,
  input  logic             pclr_i,
  input  logic             oclr_i,
  input  logic             cclr_i,
  output logic             pend_o,
  output logic             ovr_o,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             evt_q, pend_q, pend_d, ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap;

  // evt_q tracks the input even while disabled, so a level held across a
  // gen 0->1 transition does not produce a late rise.
  assign cap = gen_i & evt_i & ~evt_q;

  always_comb begin
    // A rise beats a same-cycle W1C; overrun only if PEND survives this cycle.
    pend_d = cap | (pend_q & ~pclr_i);
    ovr_d  = (cap & pend_q & ~pclr_i) | (ovr_q & ~oclr_i);
    cnt_d  = cnt_q;
    if (cclr_i)                 cnt_d = cap ? ONE : '0;
    else if (cap && cnt_q != '1) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      evt_q  <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      evt_q  <= evt_i;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o = pend_q;
  assign ovr_o  = ovr_q;
  assign cnt_o  = cnt_q;
endmodule

module vsd_timer_irq_ctrl #(
  parameter int NSRC  = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            sel,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NSRC-1:0] evt_in,
  output logic            irq
);
  logic                       wr;
  logic [5:0]                 idx;
  logic                       gen_q;
  logic [NSRC-1:0]            mask_q;
  logic [NSRC-1:0]            pend, ovr, pclr, oclr, cclr;
  logic [NSRC-1:0][CNT_W-1:0] cnt;
  logic                       unused_bits;

  assign wr  = sel & we;
  assign idx = addr[7:2];
  assign unused_bits = ^{addr[31:8], addr[1:0], wdata};

  always_comb begin
    pclr = (wr && idx == 6'd2) ? wdata[NSRC-1:0] : '0;
    oclr = (wr && idx == 6'd3) ? wdata[NSRC-1:0] : '0;
    cclr = '0;
    for (int i = 0; i < NSRC; i++) cclr[i] = wr && (idx == 6'(4 + i));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gen_q  <= 1'b0;
      mask_q <= '0;
    end else if (wr) begin
      if (idx == 6'd0) gen_q  <= wdata[0];
      if (idx == 6'd1) mask_q <= wdata[NSRC-1:0];
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_lane
    vsd_timer_irq_lane #(.CNT_W(CNT_W)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .gen_i  (gen_q),
      .evt_i  (evt_in[g]),
      .pclr_i (pclr[g]),
      .oclr_i (oclr[g]),
      .cclr_i (cclr[g]),
      .pend_o (pend[g]),
      .ovr_o  (ovr[g]),
      .cnt_o  (cnt[g])
    );
  end

  always_comb begin
    rdata = '0;
    if (sel && !we) begin
      case (idx)
        6'd0:    rdata = {31'd0, gen_q};
        6'd1:    rdata = 32'(mask_q);
        6'd2:    rdata = 32'(pend);
        6'd3:    rdata = 32'(ovr);
        default: for (int i = 0; i < NSRC; i++)
                   if (idx == 6'(4 + i)) rdata = 32'(cnt[i]);
      endcase
    end
  end

  // Built only from registered state, so no combinational glitches.
  assign irq = gen_q & |(pend & mask_q);
endmodule

// File: tb/tb_vsd_timer_irq_ctrl.sv
// Scoreboard bench: two instances share all inputs (CNT_W=8 and CNT_W=2).
// Each read pushes its expected values; a negedge monitor pops and compares
// whenever a read is presented on the bus.
module tb_vsd_timer_irq_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        sel, we;
  logic [31:0] addr, wdata, rdata_a, rdata_b;
  logic [3:0]  evt_in;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  vsd_timer_irq_ctrl #(.NSRC(4), .CNT_W(8)) u_dut (
    .clk(clk), .resetn(resetn), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata_a), .evt_in(evt_in), .irq(irq_a)
  );

  vsd_timer_irq_ctrl #(.NSRC(4), .CNT_W(2)) u_sat (
    .clk(clk), .resetn(resetn), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata_b), .evt_in(evt_in), .irq(irq_b)
  );

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        irq;
    logic [31:0] rd_b;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(string nm, string what, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s actual=%h required=%h", nm, what, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (sel === 1'b1 && we === 1'b0) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_read addr=%h", addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.nm, "rdata",   rdata_a, e.rd);
        chk(e.nm, "irq",     {31'd0, irq_a}, {31'd0, e.irq});
        chk(e.nm, "rdata_c2", rdata_b, e.rd_b);
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wr_evt(input logic [31:0] a, input logic [31:0] d, input int s);
    evt_in[s] = 1'b1;
    wr(a, d);
    evt_in[s] = 1'b0;
  endtask

  task automatic rdc(input logic [31:0] a, input logic [31:0] e, input logic [31:0] eb,
                     input logic ei, input string nm);
    exp_t x;
    x.nm = nm; x.rd = e; x.irq = ei; x.rd_b = eb;
    sb.push_back(x);
    sel = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic ei, input string nm);
    rdc(a, e, e, ei, nm);
  endtask

  task automatic pulse(input int s);
    evt_in[s] = 1'b1;
    @(posedge clk); #1;
    evt_in[s] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; evt_in = '0;
    @(posedge clk); #1;
    rd(32'h08, 0, 0, "in_reset");
    #6 resetn = 1'b1;
    @(posedge clk); #1;

    // Defaults after reset
    for (int i = 0; i < 8; i++) rd(32'(4 * i), 0, 0, "reset_dflt");

    // Single event, then W1C
    wr(32'h04, 1);
    wr(32'h00, 1);
    pulse(0);
    rd(32'h08, 1, 1, "single_pend");
    rd(32'h10, 1, 1, "single_cnt");
    wr(32'h08, 1);
    rd(32'h08, 0, 0, "pend_w1c");

    // Periodic input: 5 pulses, 6-cycle period; CNT_W=2 saturates at 3
    wr(32'h10, 0);
    repeat (5) begin pulse(0); idle(5); end
    rdc(32'h10, 5, 3, 1, "periodic_cnt");
    rd(32'h08, 1, 1, "periodic_pend");
    rd(32'h0C, 1, 1, "periodic_ovr");
    wr(32'h08, 1);
    wr(32'h0C, 1);
    rd(32'h0C, 0, 0, "ovr_w1c");

    // Masking: source 0 pends but irq stays low
    wr(32'h04, 2);
    pulse(0);
    rd(32'h08, 1, 0, "masked_pend");
    rd(32'h0C, 0, 0, "masked_ovr");
    wr(32'h04, 3);
    rd(32'h04, 3, 1, "mask_rb");
    // Disable: irq drops, edges discarded
    wr(32'h00, 0);
    rd(32'h00, 0, 0, "ctrl_off");
    pulse(1);
    rd(32'h08, 1, 0, "gen0_pend");
    rdc(32'h14, 0, 0, 0, "gen0_cnt1");

    // Simultaneous bus writes and rises
    wr(32'h00, 1);
    wr(32'h04, 32'hFFFF_FFFF);
    rd(32'h04, 32'hF, 1, "mask_wide");
    wr_evt(32'h08, 1, 0);
    rd(32'h08, 1, 1, "pend_w1c_race");
    rd(32'h0C, 0, 1, "pend_w1c_race_ovr");
    wr_evt(32'h10, 0, 0);
    rdc(32'h10, 1, 1, 1, "cnt_clr_race");
    rd(32'h0C, 1, 1, "ovr_set");
    wr_evt(32'h0C, 1, 0);
    rd(32'h0C, 1, 1, "ovr_w1c_race");
    rdc(32'h10, 2, 2, 1, "cnt_after_race");

    // Unmapped space
    wr(32'h30, 32'hFF);
    rd(32'h30, 0, 1, "unmapped_30");
    rd(32'h20, 0, 1, "unmapped_20");
    rd(32'h04, 32'hF, 1, "mask_kept");

    // Mid-run reset
    pulse(1);
    rd(32'h08, 3, 1, "pend_pre_rst");
    rdc(32'h14, 1, 1, 1, "cnt1_pre_rst");
    #2 resetn = 1'b0;
    rd(32'h08, 0, 0, "mid_rst");
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) rd(32'(4 * i), 0, 0, "post_rst");

    idle(2);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_drain left=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
